// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and seeding helper for the Trivium keystream block.
// Tap positions are 1-based as in the Trivium reference; bit n lives at vector index n-1.
package trivium_pkg;

  localparam int STATE_W = 288;
  localparam int R1_END  = 93;
  localparam int R2_END  = 177;
  localparam int R3_END  = 288;

  localparam int T1A = 66,  T1B = 93,  T1N0 = 91,  T1N1 = 92,  T1FB = 171;
  localparam int T2A = 162, T2B = 177, T2N0 = 175, T2N1 = 176, T2FB = 264;
  localparam int T3A = 243, T3B = 288, T3N0 = 286, T3N1 = 287, T3FB = 69;

  localparam int WARMUP_DEF = 1152;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} fsm_e;

  typedef logic [STATE_W-1:0] state_t;

  function automatic logic sbit(input state_t s, input int n);
    return s[n-1];
  endfunction

  function automatic state_t seed(input logic [79:0] key, input logic [79:0] iv);
    state_t s;
    s = '0;
    s[79:0] = key;
    s[R1_END+79:R1_END] = iv;
    s[STATE_W-1:STATE_W-3] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_rounds.sv
// W Trivium rounds unrolled combinationally; round j's output bit lands in z_o[j].
module trivium_rounds
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  state_t         state_i,
  output state_t         state_o,
  output logic [W-1:0]   z_o
);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("trivium_rounds: W must be one of 1,2,4,8,16,32,64");
  end

  state_t chain [W+1];

  assign chain[0] = state_i;
  assign state_o  = chain[W];

  for (genvar j = 0; j < W; j++) begin : g_round
    logic t1, t2, t3, a1, a2, a3;
    assign t1 = sbit(chain[j], T1A) ^ sbit(chain[j], T1B);
    assign t2 = sbit(chain[j], T2A) ^ sbit(chain[j], T2B);
    assign t3 = sbit(chain[j], T3A) ^ sbit(chain[j], T3B);
    assign a1 = t1 ^ (sbit(chain[j], T1N0) & sbit(chain[j], T1N1)) ^ sbit(chain[j], T1FB);
    assign a2 = t2 ^ (sbit(chain[j], T2N0) & sbit(chain[j], T2N1)) ^ sbit(chain[j], T2FB);
    assign a3 = t3 ^ (sbit(chain[j], T3N0) & sbit(chain[j], T3N1)) ^ sbit(chain[j], T3FB);
    assign z_o[j] = t1 ^ t2 ^ t3;
    // Each of the three registers shifts toward higher index, feedback enters at its low end.
    assign chain[j+1] = {chain[j][R3_END-2:R2_END], a2,
                         chain[j][R2_END-2:R1_END], a1,
                         chain[j][R1_END-2:0],      a3};
  end

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator: load seeds state, INIT runs warm-up W rounds per clock,
// RUN delivers W-bit words over valid/ready with a single output register.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W      = 8,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [79:0]   key,
  input  logic [79:0]   iv,
  output logic          busy,
  output logic          ks_valid,
  input  logic          ks_ready,
  output logic [W-1:0]  ks_data
);

  localparam int NSTEP = WARMUP / W;
  localparam int CNT_W = $clog2(NSTEP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  if (WARMUP % W != 0 || WARMUP < W) begin : g_bad_warmup
    $error("trivium_stream: WARMUP must be a positive multiple of W");
  end

  fsm_e             state_q, state_d;
  state_t           st_q, st_d, st_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     ks_data_q, ks_data_d;
  logic             ks_valid_q, ks_valid_d;
  logic [W-1:0]     z;

  trivium_rounds #(.W(W)) u_rounds (
    .state_i (st_q),
    .state_o (st_nxt),
    .z_o     (z)
  );

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    // load wins over everything, including a refill on an accepted word
    if (load) begin
      state_d    = ST_INIT;
      st_d       = seed(key, iv);
      cnt_d      = '0;
      ks_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          st_d  = st_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!ks_valid_q || ks_ready) begin
            st_d       = st_nxt;
            ks_data_d  = z;
            ks_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      st_q       <= '0;
      cnt_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  assign busy     = (state_q == ST_INIT);
  assign ks_valid = ks_valid_q;
  assign ks_data  = ks_data_q;

endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: three instances (W=8, W=64 with short warm-up, W=1) share
// stimulus; a bit-serial reference fills per-instance queues that accepted words drain.
module tb_trivium_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv = '0;
  logic        ks_ready = 1'b0;

  logic        busy8, valid8, busy64, valid64, busy1, valid1;
  logic [7:0]  ks8;
  logic [63:0] ks64;
  logic [0:0]  ks1;

  always #5 clk = ~clk;

  trivium_stream #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
    .busy(busy8), .ks_valid(valid8), .ks_ready(ks_ready), .ks_data(ks8));

  trivium_stream #(.W(64), .WARMUP(64)) u_dut64 (
    .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
    .busy(busy64), .ks_valid(valid64), .ks_ready(ks_ready), .ks_data(ks64));

  trivium_stream #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(valid1), .ks_ready(ks_ready), .ks_data(ks1));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference, indices 1..288 as in the cipher description
  int WD [0:2] = '{8, 64, 1};
  int WU [0:2] = '{1152, 64, 1152};
  bit g [0:2][1:288];
  bit exp_q [0:2][$];

  task automatic gold_seed(input int d, input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) g[d][i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      g[d][i]      = k[i-1];
      g[d][93 + i] = v[i-1];
    end
    g[d][286] = 1'b1; g[d][287] = 1'b1; g[d][288] = 1'b1;
  endtask

  function automatic bit gold_z(input int d);
    bit t1, t2, t3, z, a1, a2, a3;
    t1 = g[d][66] ^ g[d][93];
    t2 = g[d][162] ^ g[d][177];
    t3 = g[d][243] ^ g[d][288];
    z  = t1 ^ t2 ^ t3;
    a1 = t1 ^ (g[d][91] & g[d][92]) ^ g[d][171];
    a2 = t2 ^ (g[d][175] & g[d][176]) ^ g[d][264];
    a3 = t3 ^ (g[d][286] & g[d][287]) ^ g[d][69];
    for (int i = 288; i > 1; i--) g[d][i] = g[d][i-1];
    g[d][1] = a3; g[d][94] = a1; g[d][178] = a2;
    return z;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  logic [63:0] mdata [0:2];
  logic        mvalid [0:2];
  logic [63:0] prev_data [0:2];
  logic        prev_stall [0:2] = '{1'b0, 1'b0, 1'b0};
  logic        prev_load = 1'b0;

  always @(negedge clk) begin
    mdata[0] = 64'(ks8);  mvalid[0] = valid8;
    mdata[1] = ks64;      mvalid[1] = valid64;
    mdata[2] = 64'(ks1);  mvalid[2] = valid1;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        exp_q[d].delete();
        prev_stall[d] = 1'b0;
      end
      prev_load = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (prev_stall[d] && !prev_load)
          check($sformatf("stall_hold dut%0d", d), mdata[d], prev_data[d]);
        if (mvalid[d] && ks_ready) begin
          logic [63:0] expw;
          expw = '0;
          for (int j = 0; j < WD[d]; j++) begin
            if (exp_q[d].size() == 0) begin
              n_err++;
              $display("FAIL word dut%0d: got %h, want nothing (no word expected)", d, mdata[d]);
              break;
            end
            expw[j] = exp_q[d].pop_front();
            exp_q[d].push_back(gold_z(d));
          end
          check($sformatf("word dut%0d", d), mdata[d], expw);
        end
        prev_stall[d] = mvalid[d] && !ks_ready;
        prev_data[d]  = mdata[d];
      end
      if (load) begin
        for (int d = 0; d < 3; d++) begin
          gold_seed(d, key, iv);
          repeat (WU[d]) void'(gold_z(d));
          exp_q[d].delete();
          repeat (4 * WD[d]) exp_q[d].push_back(gold_z(d));
        end
      end
      prev_load = load;
    end
  end

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int duty;
    int ncyc;
    int exp_b8;
    int exp_b64;
    int exp_b1;
    int exp_v8;
    int exp_v64;
  } vec_t;

  vec_t tbl [0:5];

  // Load, measure warm-up for every instance, then stream with the given ready duty
  task automatic run_vector(input int id, input vec_t v);
    int b8, b64, b1, fv8, fv64;
    b8 = 0; b64 = 0; b1 = 0; fv8 = 0; fv64 = 0;
    @(posedge clk); #1;
    load = 1'b1; key = v.key; iv = v.iv; ks_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int idx = 1; idx <= 1160; idx++) begin
      @(negedge clk);
      if (busy8)  b8++;
      if (busy64) b64++;
      if (busy1)  b1++;
      if (valid8 && fv8 == 0)   fv8 = idx;
      if (valid64 && fv64 == 0) fv64 = idx;
    end
    check($sformatf("v%0d busy_cycles w8", id),  64'(b8),  64'(v.exp_b8));
    check($sformatf("v%0d busy_cycles w64", id), 64'(b64), 64'(v.exp_b64));
    check($sformatf("v%0d busy_cycles w1", id),  64'(b1),  64'(v.exp_b1));
    check($sformatf("v%0d first_valid w8", id),  64'(fv8), 64'(v.exp_v8));
    check($sformatf("v%0d first_valid w64", id), 64'(fv64), 64'(v.exp_v64));
    for (int c = 0; c < v.ncyc; c++) begin
      @(posedge clk); #1;
      ks_ready = ($urandom_range(0, 99) < v.duty);
    end
    @(posedge clk); #1;
    ks_ready = 1'b1;
  endtask

  initial begin
    tbl[0] = '{80'h0, 80'h0, 100, 200, 144, 1, 1152, 146, 3};
    tbl[1] = '{80'h0123456789ABCDEF0123, 80'h1, 100, 4100, 144, 1, 1152, 146, 3};
    tbl[2] = '{80'({$urandom(), $urandom(), $urandom()}), 80'({$urandom(), $urandom(), $urandom()}),
               30, 2000, 144, 1, 1152, 146, 3};
    tbl[3] = '{80'hFEDCBA9876543210FFFF, 80'hA5A5A5A5A5A5A5A5A5A5, 100, 50, 144, 1, 1152, 146, 3};
    tbl[4] = '{80'h13579BDF02468ACE1122, 80'h0F0F0F0F0F0F0F0F0F0F, 50, 100, 144, 1, 1152, 146, 3};
    tbl[5] = '{80'h1, 80'h2, 100, 50, 144, 1, 1152, 146, 3};

    #2;
    check("reset busy8",   64'(busy8),  64'd0);
    check("reset valid8",  64'(valid8), 64'd0);
    check("reset data8",   64'(ks8),    64'd0);
    check("reset valid64", 64'(valid64), 64'd0);
    check("reset data64",  ks64,         64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle busy8", 64'(busy8), 64'd0);

    for (int i = 0; i < 3; i++) run_vector(i, tbl[i]);

    // Restart during INIT: first load, then another 50 cycles later
    @(posedge clk); #1;
    load = 1'b1; key = 80'hDEAD; iv = 80'hBEEF;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (48) @(posedge clk);
    run_vector(3, tbl[3]);

    // Restart during RUN while a word is being handed over
    @(negedge clk);
    check("run_handshake valid8", 64'(valid8 & ks_ready), 64'd1);
    run_vector(4, tbl[4]);

    // Asynchronous reset between edges while streaming
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst valid8",  64'(valid8),  64'd0);
    check("async_rst busy8",   64'(busy8),   64'd0);
    check("async_rst data8",   64'(ks8),     64'd0);
    check("async_rst valid64", 64'(valid64), 64'd0);
    check("async_rst data64",  ks64,         64'd0);
    check("async_rst busy1",   64'(busy1),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (valid8 || valid64 || valid1 || busy8) seen++;
      end
      check("post_rst quiet", 64'(seen), 64'd0);
    end
    run_vector(5, tbl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
